// File: rtl/bike_motion_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bike_pkg
// Brief    : Shared screen geometry, heading, state and turn encodings for
//            the light-bike motion controller.
// Revision : 1.0 - initial release
// ============================================================================
package bike_pkg;

    // Visible raster geometry; address = y*SCREEN_W + x
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Heading encodings; +1 is a left turn, -1 a right turn (mod 4)
    localparam logic [1:0] ORIENT_UP    = 2'd0;
    localparam logic [1:0] ORIENT_LEFT  = 2'd1;
    localparam logic [1:0] ORIENT_DOWN  = 2'd2;
    localparam logic [1:0] ORIENT_RIGHT = 2'd3;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CRASH = 2'd2;

    // Pending-turn codes
    typedef enum logic [1:0] {
        TURN_NONE  = 2'd0,
        TURN_LEFT  = 2'd1,
        TURN_RIGHT = 2'd2
    } turn_e;

    // Heading after applying a turn code
    function automatic logic [1:0] apply_turn(input logic [1:0] orient, input turn_e turn);
        logic [1:0] res;
        res = orient;
        if (turn == TURN_LEFT)  res = orient + 2'd1;
        if (turn == TURN_RIGHT) res = orient - 2'd1;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bike_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bike_motion_ctrl_if
// Brief    : Frame/button/detector inputs and position outputs of one bike.
//            master = stimulus side (timing, buttons, detector),
//            slave  = motion controller.
// Revision : 1.0 - initial release
// ============================================================================
interface bike_motion_ctrl_if;
    logic        frame_tick;
    logic        start;
    logic        turn_left;
    logic        turn_right;
    logic        background_detected;
    logic [18:0] bikeLocation_middle;
    logic [1:0]  bike_orient;
    logic        crashed;
    logic        move_strobe;

    modport master (
        output frame_tick, start, turn_left, turn_right, background_detected,
        input  bikeLocation_middle, bike_orient, crashed, move_strobe
    );

    modport slave (
        input  frame_tick, start, turn_left, turn_right, background_detected,
        output bikeLocation_middle, bike_orient, crashed, move_strobe
    );
endinterface
`default_nettype wire

// File: rtl/bike_motion_ctrl_turn_capture.sv
`default_nettype none
// ============================================================================
// Module   : turn_capture
// Brief    : Button rising-edge detection and single pending-turn register.
//            Opposite edges cancel each other; a move event consumes the
//            pending turn; clear discards it.
// Revision : 1.0 - initial release
// ============================================================================
module turn_capture
    import bike_pkg::*;
(
    input  wire   clk,
    input  wire   rst,
    input  wire   i_enable,      // edges are accepted only while running
    input  wire   i_clear,       // discard any pending turn
    input  wire   i_consume,     // move event takes the pending turn
    input  wire   i_turn_left,
    input  wire   i_turn_right,
    output turn_e o_pending
);

    logic  r_prev_left;
    logic  r_prev_right;
    turn_e r_pending;
    turn_e w_base;
    turn_e w_next;
    logic  w_left_edge;
    logic  w_right_edge;

    assign w_left_edge  = i_enable & i_turn_left  & ~r_prev_left;
    assign w_right_edge = i_enable & i_turn_right & ~r_prev_right;

    // Next pending turn: consumption first, then new edges with cancel rules
    always_comb begin
        w_base = i_consume ? TURN_NONE : r_pending;
        w_next = w_base;
        if (w_left_edge && w_right_edge) begin
            w_next = TURN_NONE;
        end else if (w_left_edge) begin
            w_next = (w_base == TURN_RIGHT) ? TURN_NONE : TURN_LEFT;
        end else if (w_right_edge) begin
            w_next = (w_base == TURN_LEFT) ? TURN_NONE : TURN_RIGHT;
        end
        if (i_clear) begin
            w_next = TURN_NONE;
        end
    end

    // Button history tracks continuously so a held button never yields a
    // spurious edge when the round starts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_left  <= 1'b0;
            r_prev_right <= 1'b0;
            r_pending    <= TURN_NONE;
        end else begin
            r_prev_left  <= i_turn_left;
            r_prev_right <= i_turn_right;
            r_pending    <= w_next;
        end
    end

    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/bike_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bike_motion_ctrl
// Brief    : Position/heading controller for one light-bike. Moves every
//            FRAMES_PER_MOVE frames, crashes on detector hits or when the
//            next step would leave the margin-bounded play field.
// Revision : 1.0 - initial release
// ============================================================================
module bike_motion_ctrl
    import bike_pkg::*;
#(
    parameter int START_X         = 320,
    parameter int START_Y         = 400,
    parameter int STEP            = 1,
    parameter int FRAMES_PER_MOVE = 2,
    parameter int MARGIN          = 16
) (
    input  wire              clock,
    input  wire              reset,
    bike_motion_ctrl_if.slave bus
);

    localparam int          CNT_W   = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FRAMES_PER_MOVE - 1);
    localparam logic [9:0]  C_START_X = 10'(START_X);
    localparam logic [8:0]  C_START_Y = 9'(START_Y);
    localparam logic [18:0] C_START_ADDR = 19'(START_Y * SCREEN_W + START_X);
    localparam logic [11:0] C_STEP    = 12'(STEP);
    localparam logic [11:0] C_MIN     = 12'(MARGIN);
    localparam logic [11:0] C_MAX_X   = 12'(SCREEN_W - 1 - MARGIN);
    localparam logic [11:0] C_MAX_Y   = 12'(SCREEN_H - 1 - MARGIN);

    logic [1:0]       r_state;
    logic [9:0]       r_x;
    logic [8:0]       r_y;
    logic [1:0]       r_orient;
    logic [18:0]      r_addr;
    logic             r_hit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_strobe;

    turn_e            w_pending;
    logic             w_run;
    logic             w_tick_crash;
    logic             w_move;
    logic             w_clear_turn;
    logic [1:0]       w_orient_next;
    logic [11:0]      w_nx;
    logic [11:0]      w_ny;
    logic             w_out_of_bounds;
    logic [18:0]      w_addr_next;

    assign w_run        = (r_state == ST_RUN);
    assign w_tick_crash = r_hit | bus.background_detected;
    assign w_move       = w_run & bus.frame_tick & ~w_tick_crash & (r_cnt == C_CNT_LAST);
    // Pending turn is dropped whenever we are not running or a tick crashes
    assign w_clear_turn = ~w_run | (bus.frame_tick & w_tick_crash);

    turn_capture u_turn_capture (
        .clk          (clock),
        .rst          (reset),
        .i_enable     (w_run),
        .i_clear      (w_clear_turn),
        .i_consume    (w_move),
        .i_turn_left  (bus.turn_left),
        .i_turn_right (bus.turn_right),
        .o_pending    (w_pending)
    );

    // Candidate heading/position for a move event; wrap below zero reads as
    // a huge unsigned value, so one upper-bound compare also catches it
    always_comb begin
        w_orient_next = apply_turn(r_orient, w_pending);
        w_nx = {2'b00, r_x};
        w_ny = {3'b000, r_y};
        case (w_orient_next)
            ORIENT_UP:    w_ny = {3'b000, r_y} - C_STEP;
            ORIENT_LEFT:  w_nx = {2'b00, r_x} - C_STEP;
            ORIENT_DOWN:  w_ny = {3'b000, r_y} + C_STEP;
            default:      w_nx = {2'b00, r_x} + C_STEP;
        endcase
        w_out_of_bounds = (w_nx < C_MIN) || (w_nx > C_MAX_X) ||
                          (w_ny < C_MIN) || (w_ny > C_MAX_Y);
        // y*640 = (y<<9) + (y<<7)
        w_addr_next = ({10'd0, w_ny[8:0]} << 9) + ({10'd0, w_ny[8:0]} << 7) + {9'd0, w_nx[9:0]};
    end

    // Round state machine, position registers and move strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_x      <= C_START_X;
            r_y      <= C_START_Y;
            r_orient <= ORIENT_UP;
            r_addr   <= C_START_ADDR;
            r_hit    <= 1'b0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_hit   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.frame_tick) begin
                        if (w_tick_crash) begin
                            r_state <= ST_CRASH;
                        end else begin
                            r_hit <= 1'b0;
                            if (r_cnt == C_CNT_LAST) begin
                                r_cnt <= '0;
                                if (w_out_of_bounds) begin
                                    r_state <= ST_CRASH;
                                end else begin
                                    r_x      <= w_nx[9:0];
                                    r_y      <= w_ny[8:0];
                                    r_orient <= w_orient_next;
                                    r_addr   <= w_addr_next;
                                    r_strobe <= 1'b1;
                                end
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end else if (bus.background_detected) begin
                        r_hit <= 1'b1;
                    end
                end
                ST_CRASH: begin
                    if (bus.start) begin
                        r_state  <= ST_RUN;
                        r_x      <= C_START_X;
                        r_y      <= C_START_Y;
                        r_orient <= ORIENT_UP;
                        r_addr   <= C_START_ADDR;
                        r_hit    <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bikeLocation_middle = r_addr;
    assign bus.bike_orient         = r_orient;
    assign bus.crashed             = (r_state == ST_CRASH);
    assign bus.move_strobe         = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_bike_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bike_motion_ctrl
// Brief    : Directed self-checking bench for bike_motion_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bike_motion_ctrl;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   n_strobe;

    bike_motion_ctrl_if bif ();
    bike_motion_ctrl_if bif2 ();

    bike_motion_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave)
    );

    // Second instance starts on the top margin so the first up-move crashes
    bike_motion_ctrl #(.START_Y(16)) dut_edge (
        .clock (clock),
        .reset (reset),
        .bus   (bif2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge, then settle away from the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Counts strobes seen at the sample point of each step
    task automatic step_count();
        step();
        if (bif.move_strobe === 1'b1) n_strobe++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_start();
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
    endtask

    task automatic tick();
        bif.frame_tick = 1'b1;
        step_count();
        bif.frame_tick = 1'b0;
    endtask

    task automatic press_left();
        bif.turn_left = 1'b1;
        step();
        bif.turn_left = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bif.bikeLocation_middle !== 19'd256320) begin
            n_bad++; $display("FAIL reset_addr got %0d want 256320", bif.bikeLocation_middle);
        end
        n_cmp++;
        if (bif.bike_orient !== 2'd0 || bif.crashed !== 1'b0 || bif.move_strobe !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got o=%0d c=%0d s=%0d want 0/0/0",
                              bif.bike_orient, bif.crashed, bif.move_strobe);
        end
        // IDLE ignores ticks without start
        tick(); tick();
        n_cmp++;
        if (bif.bikeLocation_middle !== 19'd256320 || n_strobe !== 0) begin
            n_bad++; $display("FAIL idle_hold got addr=%0d strobes=%0d want 256320/0",
                              bif.bikeLocation_middle, n_strobe);
        end
    endtask

    task automatic test_straight();
        do_reset();
        do_start();
        n_strobe = 0;
        tick();
        step_count();
        n_cmp++;
        if (bif.bikeLocation_middle !== 19'd256320) begin
            n_bad++; $display("FAIL straight_first_tick got %0d want 256320", bif.bikeLocation_middle);
        end
        tick();
        n_cmp++;
        if (bif.move_strobe !== 1'b1 || bif.bikeLocation_middle !== 19'd255680) begin
            n_bad++; $display("FAIL straight_move1 got s=%0d addr=%0d want 1/255680",
                              bif.move_strobe, bif.bikeLocation_middle);
        end
        step_count();
        tick(); step_count();
        tick(); step_count();
        n_cmp++;
        if (bif.bikeLocation_middle !== 19'd255040 || bif.bike_orient !== 2'd0) begin
            n_bad++; $display("FAIL straight_move2 got addr=%0d o=%0d want 255040/0",
                              bif.bikeLocation_middle, bif.bike_orient);
        end
        n_cmp++;
        if (n_strobe !== 2) begin
            n_bad++; $display("FAIL straight_strobes got %0d want 2", n_strobe);
        end
    endtask

    task automatic test_turn_right_and_crash();
        do_reset();
        do_start();
        bif.turn_right = 1'b1;
        step();
        bif.turn_right = 1'b0;
        step();
        tick(); step();
        tick();
        n_cmp++;
        if (bif.move_strobe !== 1'b1 || bif.bike_orient !== 2'd3 ||
            bif.bikeLocation_middle !== 19'd256321) begin
            n_bad++; $display("FAIL turn_right got s=%0d o=%0d addr=%0d want 1/3/256321",
                              bif.move_strobe, bif.bike_orient, bif.bikeLocation_middle);
        end
        step();
        // Single-cycle detector hit mid-frame
        bif.background_detected = 1'b1;
        step();
        bif.background_detected = 1'b0;
        step(); step();
        n_strobe = 0;
        tick();
        n_cmp++;
        if (bif.crashed !== 1'b1 || bif.bikeLocation_middle !== 19'd256321) begin
            n_bad++; $display("FAIL crash_hit got c=%0d addr=%0d want 1/256321",
                              bif.crashed, bif.bikeLocation_middle);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); step_count();
        end
        n_cmp++;
        if (n_strobe !== 0 || bif.bikeLocation_middle !== 19'd256321 || bif.crashed !== 1'b1) begin
            n_bad++; $display("FAIL crash_frozen got strobes=%0d addr=%0d c=%0d want 0/256321/1",
                              n_strobe, bif.bikeLocation_middle, bif.crashed);
        end
        do_start();
        n_cmp++;
        if (bif.crashed !== 1'b0 || bif.bikeLocation_middle !== 19'd256320 || bif.bike_orient !== 2'd0) begin
            n_bad++; $display("FAIL restart got c=%0d addr=%0d o=%0d want 0/256320/0",
                              bif.crashed, bif.bikeLocation_middle, bif.bike_orient);
        end
    endtask

    task automatic test_turn_cancel_and_left();
        do_reset();
        do_start();
        bif.turn_left  = 1'b1;
        bif.turn_right = 1'b1;
        step();
        bif.turn_left  = 1'b0;
        bif.turn_right = 1'b0;
        step();
        tick(); step(); tick();
        n_cmp++;
        if (bif.bike_orient !== 2'd0 || bif.bikeLocation_middle !== 19'd255680) begin
            n_bad++; $display("FAIL cancel_same_cycle got o=%0d addr=%0d want 0/255680",
                              bif.bike_orient, bif.bikeLocation_middle);
        end
        // Left then right edge cancels too
        press_left();
        bif.turn_right = 1'b1; step(); bif.turn_right = 1'b0; step();
        tick(); step(); tick();
        n_cmp++;
        if (bif.bike_orient !== 2'd0 || bif.bikeLocation_middle !== 19'd255040) begin
            n_bad++; $display("FAIL cancel_sequential got o=%0d addr=%0d want 0/255040",
                              bif.bike_orient, bif.bikeLocation_middle);
        end
        // Single left: heading left, x 320 -> 319 at y 398
        press_left();
        tick(); step(); tick();
        n_cmp++;
        if (bif.bike_orient !== 2'd1 || bif.bikeLocation_middle !== 19'd255039) begin
            n_bad++; $display("FAIL turn_left got o=%0d addr=%0d want 1/255039",
                              bif.bike_orient, bif.bikeLocation_middle);
        end
        // Two left presses before one move give one turn: down, y 398 -> 399
        press_left();
        press_left();
        tick(); step(); tick();
        n_cmp++;
        if (bif.bike_orient !== 2'd2 || bif.bikeLocation_middle !== 19'd255679) begin
            n_bad++; $display("FAIL repeat_left got o=%0d addr=%0d want 2/255679",
                              bif.bike_orient, bif.bikeLocation_middle);
        end
    endtask

    task automatic test_margin_crash();
        do_reset();
        bif2.start = 1'b1; step(); bif2.start = 1'b0;
        bif2.frame_tick = 1'b1; step(); bif2.frame_tick = 1'b0; step();
        bif2.frame_tick = 1'b1; step(); bif2.frame_tick = 1'b0;
        n_cmp++;
        if (bif2.crashed !== 1'b1 || bif2.move_strobe !== 1'b0 ||
            bif2.bikeLocation_middle !== 19'd10560 || bif2.bike_orient !== 2'd0) begin
            n_bad++; $display("FAIL margin_crash got c=%0d s=%0d addr=%0d o=%0d want 1/0/10560/0",
                              bif2.crashed, bif2.move_strobe, bif2.bikeLocation_middle, bif2.bike_orient);
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        do_start();
        tick(); step();
        bif.frame_tick = 1'b1;
        reset = 1'b1;
        step();
        bif.frame_tick = 1'b0;
        reset = 1'b0;
        n_cmp++;
        if (bif.bikeLocation_middle !== 19'd256320 || bif.move_strobe !== 1'b0 || bif.crashed !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_move got addr=%0d s=%0d c=%0d want 256320/0/0",
                              bif.bikeLocation_middle, bif.move_strobe, bif.crashed);
        end
        // Back in IDLE: ticks must not move the bike
        n_strobe = 0;
        tick(); step_count(); tick(); step_count();
        n_cmp++;
        if (n_strobe !== 0 || bif.bikeLocation_middle !== 19'd256320) begin
            n_bad++; $display("FAIL reset_to_idle got strobes=%0d addr=%0d want 0/256320",
                              n_strobe, bif.bikeLocation_middle);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_strobe = 0;
        reset = 1'b1;
        bif.frame_tick = 1'b0;  bif.start = 1'b0;  bif.turn_left = 1'b0;
        bif.turn_right = 1'b0;  bif.background_detected = 1'b0;
        bif2.frame_tick = 1'b0; bif2.start = 1'b0; bif2.turn_left = 1'b0;
        bif2.turn_right = 1'b0; bif2.background_detected = 1'b0;
        test_reset();
        test_straight();
        test_turn_right_and_crash();
        test_turn_cancel_and_left();
        test_margin_crash();
        test_reset_mid_move();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
